// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load, clear, hold and multi-position
// shift/rotate. A shift runs one bit position per clock. The operation is
// started by a start pulse; busy stays high while it runs and done pulses
// once, in the cycle that shows the final q.
//
//   state | meaning
//   IDLE  | waiting for start; single-cycle ops and the first shift run here
//   SHIFT | performing the remaining shifts of a multi-position op
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [2:0]       op_r;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] shifted;
  logic             out_bit;

  // One-position shift of the current q. In IDLE the incoming op is used so
  // that the first shift can happen on the accept edge.
  always_comb begin
    sel_op  = (state == IDLE) ? op : op_r;
    shifted = q;
    out_bit = 1'b0;
    case (sel_op)
      OP_SHL: begin
        shifted = {q[WIDTH-2:0], ser_in};
        out_bit = q[WIDTH-1];
      end
      OP_SHR: begin
        shifted = {ser_in, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ROL: begin
        shifted = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      OP_ROR: begin
        shifted = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ASR: begin
        shifted = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        shifted = q;
        out_bit = 1'b0;
      end
    endcase
  end

  // Sequencer: accept requests in IDLE, run remaining shifts in SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_r    <= OP_HOLD;
      cnt     <= '0;
      q       <= '0;
      ser_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r <= op;
            case (op)
              OP_HOLD: done <= 1'b1;
              OP_LOAD: begin
                q       <= load_data;
                ser_out <= 1'b0;
                done    <= 1'b1;
              end
              OP_CLEAR: begin
                q       <= '0;
                ser_out <= 1'b0;
                done    <= 1'b1;
              end
              default: begin
                if (amount == '0) begin
                  done <= 1'b1;
                end else begin
                  q       <= shifted;
                  ser_out <= out_bit;
                  if (amount == AMT_W'(1)) begin
                    done <= 1'b1;
                  end else begin
                    cnt   <= amount - AMT_W'(1);
                    busy  <= 1'b1;
                    state <= SHIFT;
                  end
                end
              end
            endcase
          end
        end
        SHIFT: begin
          q       <= shifted;
          ser_out <= out_bit;
          cnt     <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: a vector table of chained operations
// with hand-derived results, checked through a done-driven scoreboard, plus
// directed sequences for back-to-back start, start while busy and reset abort.
module tb_universal_shift_register;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3;
  localparam logic [2:0] ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, CLR = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [3:0] amount = 4'd0;
  logic [7:0] load_data = 8'd0;
  logic       ser_in = 1'b0;
  logic [7:0] q;
  logic       ser_out, busy, done;

  universal_shift_register #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amount(amount),
    .load_data(load_data), .ser_in(ser_in), .q(q), .ser_out(ser_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       so;
    int         lat;
    string      name;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] data;
    logic       sin;
    logic [7:0] eq;
    logic       eso;
    int         elat;
    string      name;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[16];
  int   checks = 0, failures = 0;
  int   cyc = 0, acc_cyc = 0, bcnt = 0, dcount = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every done pulse retires the oldest outstanding request.
  always @(negedge clk) begin
    if (busy === 1'b1) bcnt++;
    if (done === 1'b1) begin
      exp_t e;
      dcount++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 with q=0x%0h expected no done", q);
      end else begin
        e = sbq.pop_front();
        chk({e.name, ".q"}, 32'(q), 32'(e.q));
        chk({e.name, ".ser_out"}, 32'(ser_out), 32'(e.so));
        chk({e.name, ".latency"}, 32'(cyc - acc_cyc), 32'(e.lat));
        chk({e.name, ".busy_cycles"}, 32'(bcnt), 32'(e.lat));
      end
    end
  end

  task automatic issue_start(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d,
                             input logic s, input logic [7:0] eq, input logic eso,
                             input int elat, input string nm);
    exp_t e;
    @(negedge clk);
    op = o; amount = a; load_data = d; ser_in = s; start = 1'b1;
    e.q = eq; e.so = eso; e.lat = elat; e.name = nm;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bcnt = 0;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout: got no done after %0d cycles expected done", nm, n);
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    vt[0]  = '{LOAD, 4'd0,  8'hA5, 1'b0, 8'hA5, 1'b0, 0,  "load_a5"};
    vt[1]  = '{SHL,  4'd3,  8'h00, 1'b1, 8'h2F, 1'b1, 2,  "shl3"};
    vt[2]  = '{LOAD, 4'd0,  8'h81, 1'b0, 8'h81, 1'b0, 0,  "load_81"};
    vt[3]  = '{ROR,  4'd10, 8'h00, 1'b0, 8'h60, 1'b0, 9,  "ror10"};
    vt[4]  = '{LOAD, 4'd0,  8'h90, 1'b0, 8'h90, 1'b0, 0,  "load_90"};
    vt[5]  = '{ASR,  4'd2,  8'h00, 1'b0, 8'hE4, 1'b0, 1,  "asr2"};
    vt[6]  = '{SHL,  4'd0,  8'h00, 1'b1, 8'hE4, 1'b0, 0,  "shl0"};
    vt[7]  = '{SHR,  4'd3,  8'h00, 1'b0, 8'h1C, 1'b1, 2,  "shr3"};
    vt[8]  = '{HOLD, 4'd5,  8'hFF, 1'b0, 8'h1C, 1'b1, 0,  "hold"};
    vt[9]  = '{ROL,  4'd12, 8'h00, 1'b0, 8'hC1, 1'b1, 11, "rol12"};
    vt[10] = '{CLR,  4'd3,  8'hFF, 1'b1, 8'h00, 1'b0, 0,  "clear"};
    vt[11] = '{SHR,  4'd15, 8'h00, 1'b1, 8'hFF, 1'b1, 14, "shr15_fill"};
    vt[12] = '{ASR,  4'd1,  8'h00, 1'b0, 8'hFF, 1'b1, 0,  "asr1"};
    vt[13] = '{LOAD, 4'd0,  8'h7E, 1'b0, 8'h7E, 1'b0, 0,  "load_7e"};
    vt[14] = '{ASR,  4'd3,  8'h00, 1'b0, 8'h0F, 1'b1, 2,  "asr3"};
    vt[15] = '{SHL,  4'd8,  8'h00, 1'b0, 8'h00, 1'b1, 7,  "shl8_fill"};

    // Reset held for two cycles while a LOAD request is presented.
    start = 1'b1; op = LOAD; load_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.q", 32'(q), 32'h00);
    chk("reset.busy", 32'(busy), 32'h0);
    chk("reset.done", 32'(done), 32'h0);
    chk("reset.ser_out", 32'(ser_out), 32'h0);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;

    // Intermediate values of the first multi-cycle shift.
    issue_start(vt[0].op, vt[0].amt, vt[0].data, vt[0].sin, vt[0].eq, vt[0].eso, vt[0].elat, vt[0].name);
    wait_done(vt[0].name);
    issue_start(vt[1].op, vt[1].amt, vt[1].data, vt[1].sin, vt[1].eq, vt[1].eso, vt[1].elat, vt[1].name);
    chk("shl3.step1", 32'(q), 32'h4B);
    chk("shl3.busy1", 32'(busy), 32'h1);
    @(posedge clk);
    #1;
    chk("shl3.step2", 32'(q), 32'h97);
    wait_done(vt[1].name);

    for (int i = 2; i < 16; i++) begin
      issue_start(vt[i].op, vt[i].amt, vt[i].data, vt[i].sin, vt[i].eq, vt[i].eso, vt[i].elat, vt[i].name);
      wait_done(vt[i].name);
    end

    // Back-to-back: ROL accepted in the cycle that carries the LOAD's done.
    issue_start(LOAD, 4'd0, 8'h55, 1'b0, 8'h55, 1'b0, 0, "b2b_load");
    issue_start(ROL, 4'd1, 8'h00, 1'b0, 8'hAA, 1'b0, 0, "b2b_rol1");
    wait_done("b2b_rol1");

    // CLEAR requested during a busy ROL must be ignored.
    issue_start(LOAD, 4'd0, 8'h0F, 1'b0, 8'h0F, 1'b0, 0, "load_0f");
    wait_done("load_0f");
    issue_start(ROL, 4'd5, 8'h00, 1'b0, 8'hE1, 1'b1, 4, "rol5_ignore_clr");
    @(negedge clk);
    op = CLR; amount = 4'd1; load_data = 8'h00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ignore_clr.busy", 32'(busy), 32'h1);
    wait_done("rol5_ignore_clr");

    // Reset on the third cycle of a 7-position shift aborts without done.
    issue_start(LOAD, 4'd0, 8'hC3, 1'b0, 8'hC3, 1'b0, 0, "load_c3");
    wait_done("load_c3");
    d0 = dcount;
    @(negedge clk);
    op = SHL; amount = 4'd7; ser_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.q", 32'(q), 32'h00);
    chk("abort.busy", 32'(busy), 32'h0);
    chk("abort.ser_out", 32'(ser_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort.no_done", 32'(dcount - d0), 32'h0);
    start = 1'b1; op = LOAD; load_data = 8'h3C; ser_in = 1'b0; amount = 4'd0;
    begin
      exp_t e;
      e.q = 8'h3C; e.so = 1'b0; e.lat = 0; e.name = "post_abort_load";
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bcnt = 0;
    start = 1'b0;
    wait_done("post_abort_load");
    repeat (3) @(negedge clk);
    chk("final.no_extra_done", 32'(dcount - d0), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the fixed 4-bit parallel-in/parallel-out register.
- Parallel load, clear, and multi-position shift/rotate, sequenced one bit position per clock, with serial in/out and a start/busy/done handshake.
- Sits between datapath blocks that need serial-to-parallel conversion, parallel-to-serial conversion or bit alignment. Results are exposed on a parallel output.

Parameters:
- WIDTH, 8: register width in bits; must be at least 2.
- AMT_W, 4: width of the shift-amount field. Legal amounts are 0 to 2^AMT_W-1 and may exceed WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  3  operation code, latched when start is accepted.
- amount  in  AMT_W  number of shift positions, latched when start is accepted.
- load_data  in  WIDTH  parallel data for LOAD, sampled on the accept edge.
- ser_in  in  1  serial input bit; sampled live on every shift edge, not latched.
- q  out  WIDTH  parallel register contents (registered).
- ser_out  out  1  bit shifted out on the most recent shift edge (registered).
- busy  out  1  high while a multi-cycle operation is in progress.
- done  out  1  one-cycle pulse, coincident with the final q value.

Behaviour:
- Reset: rst is synchronous and active-high, with clock clk. On reset: q=0, ser_out=0, busy=0, done=0, state=IDLE, internal counter=0. Reset mid-operation aborts immediately; no done pulse is issued.
- Op codes:
  - 000 HOLD: q unchanged.
  - 001 LOAD: q<=load_data.
  - 010 SHL: q<={q[W-2:0],ser_in}; out bit q[W-1].
  - 011 SHR: q<={ser_in,q[W-1:1]}; out bit q[0].
  - 100 ROL: q<={q[W-2:0],q[W-1]}; out bit q[W-1].
  - 101 ROR: q<={q[0],q[W-1:1]}; out bit q[0].
  - 110 ASR: q<={q[W-1],q[W-1:1]}; out bit q[0].
  - 111 CLEAR: q<=0.
- States: IDLE and SHIFT.
- IDLE with start=1 at edge k:
  - HOLD, LOAD and CLEAR execute at edge k and stay in IDLE. done=1 for the cycle after edge k.
  - LOAD and CLEAR also set ser_out=0. HOLD leaves ser_out unchanged.
  - Shift ops with amount=0: q and ser_out unchanged, done=1 after edge k, busy stays 0.
  - Shift ops with amount N>=1: the first shift happens at edge k and ser_out takes the out bit.
    - N=1: stay in IDLE; done=1 after edge k.
    - N>1: go to SHIFT with counter=N-1 and busy=1.
- SHIFT state:
  - Each edge performs one shift of the latched op and decrements the counter.
  - The edge that brings the counter to 0 returns to IDLE, sets busy=0 and done=1.
  - The final q therefore appears after edge k+N-1; busy is high for N-1 cycles.
- Rotates with N>WIDTH wrap naturally; no modulo reduction is applied.
- Logical shifts with N>=WIDTH leave q made entirely of ser_in bits.
- start while busy=1 is ignored; the latched op and amount are unaffected. Changes to op, amount and load_data while busy have no effect.
- A start in the IDLE cycle that carries done=1 is accepted normally, so operations can run back-to-back.
- Without start, IDLE holds all values and done=0.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 and op=LOAD -> q=0x00, busy=0, done=0, ser_out=0.
- LOAD then SHL: LOAD load_data=0xA5 -> q=0xA5 and a done pulse on the next cycle. Then SHL amount=3 with ser_in=1 -> q passes 0x4B, then 0x97, then 0x2F. ser_out=1 at the end; busy high for exactly 2 cycles; done coincides with q=0x2F.
- Rotate wrap: LOAD 0x81, then ROR amount=10 -> q=0x60 after 10 cycles; busy high for 9 cycles; ser_out=0.
- ASR sign fill: LOAD 0x90, then ASR amount=2 -> q=0xE4; ser_out=0.
- Boundaries:
  - SHL amount=0 -> q unchanged, done after 1 cycle, busy never high.
  - start with op=CLEAR during a busy ROL -> ignored; the ROL completes with a correct q.
- Reset mid-shift: during SHL amount=7, assert rst on the 3rd cycle -> q=0 and busy=0, with no done pulse. A new LOAD 0x3C is accepted on the next cycle.
